// File: rtl/mdio_responder.sv
// +----------------------------------------------------------------------------+
// | mdio_responder : Clause 22 MDIO target, oversampled in the clk domain.     |
// | Option macro MDIO_RESPONDER_PREAMBLE_SUPPRESS_EN.  Revision 1.0            |
// +----------------------------------------------------------------------------+
`default_nettype none

module mdio_responder #(
   parameter logic [4:0] PHY_ADDR = 5'd1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        mdc_i,
   input  logic        mdio_i,
   output logic        mdio_o,
   output logic        mdio_oe,
   output logic [4:0]  reg_addr,
   output logic        rd_req,
   input  logic [15:0] rd_data,
   output logic        wr_en,
   output logic [15:0] wr_data,
   output logic        busy
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_ST2  = 3'd1,
      S_OP   = 3'd2,
      S_ADDR = 3'd3,
      S_TA   = 3'd4,
      S_DATA = 3'd5
   } state_t;

`ifdef MDIO_RESPONDER_PREAMBLE_SUPPRESS_EN
   localparam logic [5:0] PRE_MIN = 6'd1;
`else
   localparam logic [5:0] PRE_MIN = 6'd32;
`endif

   logic mdc_s1, mdc_s2, mdc_s3, mdc_edge;
   logic mdio_s1, mdio_s2, mdio_s3;

   state_t      state;
   logic [5:0]  pre_cnt;
   logic [3:0]  cnt;
   logic [1:0]  op;
   logic [8:0]  addr_sh;
   logic [15:0] data_sh;
   logic        sel;
   logic        is_rd;

   // mdio_s3 is delayed one extra stage so it lines up with the registered edge event.
   always_ff @(posedge clk) begin
      if (reset) begin
         mdc_s1   <= 1'b0;
         mdc_s2   <= 1'b0;
         mdc_s3   <= 1'b0;
         mdc_edge <= 1'b0;
         mdio_s1  <= 1'b0;
         mdio_s2  <= 1'b0;
         mdio_s3  <= 1'b0;
      end else begin
         mdc_s1   <= mdc_i;
         mdc_s2   <= mdc_s1;
         mdc_s3   <= mdc_s2;
         mdc_edge <= mdc_s2 & ~mdc_s3;
         mdio_s1  <= mdio_i;
         mdio_s2  <= mdio_s1;
         mdio_s3  <= mdio_s2;
      end
   end

   always_ff @(posedge clk) begin
      rd_req <= 1'b0;
      wr_en  <= 1'b0;
      if (reset) begin
         state    <= S_IDLE;
         pre_cnt  <= 6'd0;
         cnt      <= 4'd0;
         op       <= 2'b00;
         addr_sh  <= 9'd0;
         data_sh  <= 16'd0;
         sel      <= 1'b0;
         is_rd    <= 1'b0;
         mdio_o   <= 1'b0;
         mdio_oe  <= 1'b0;
         reg_addr <= 5'd0;
         wr_data  <= 16'd0;
         busy     <= 1'b0;
      end else if (mdc_edge) begin
         case (state)
            S_IDLE: begin
               if (mdio_s3) begin
                  if (pre_cnt != 6'd32) pre_cnt <= pre_cnt + 6'd1;
               end else if (pre_cnt >= PRE_MIN) begin
                  state   <= S_ST2;
                  busy    <= 1'b1;
                  pre_cnt <= 6'd0;
               end else begin
                  pre_cnt <= 6'd0;
               end
            end
            S_ST2: begin
               cnt <= 4'd0;
               if (mdio_s3) begin
                  state <= S_OP;
               end else begin
                  state <= S_IDLE;
                  busy  <= 1'b0;
               end
            end
            S_OP: begin
               op  <= {op[0], mdio_s3};
               cnt <= cnt + 4'd1;
               if (cnt == 4'd1) begin
                  state <= S_ADDR;
                  cnt   <= 4'd0;
               end
            end
            S_ADDR: begin
               addr_sh <= {addr_sh[7:0], mdio_s3};
               cnt     <= cnt + 4'd1;
               if (cnt == 4'd9) begin
                  state <= S_TA;
                  cnt   <= 4'd0;
                  is_rd <= (op == 2'b10);
                  sel   <= (addr_sh[8:4] == PHY_ADDR) && (op == 2'b10 || op == 2'b01);
                  if ((addr_sh[8:4] == PHY_ADDR) && (op == 2'b10 || op == 2'b01)) begin
                     reg_addr <= {addr_sh[3:0], mdio_s3};
                     rd_req   <= (op == 2'b10);
                  end
               end
            end
            S_TA: begin
               cnt <= cnt + 4'd1;
               if (cnt == 4'd0) begin
                  if (sel && is_rd) begin
                     data_sh <= rd_data;
                     mdio_oe <= 1'b1;
                     mdio_o  <= 1'b0;
                  end
               end else begin
                  state <= S_DATA;
                  cnt   <= 4'd0;
                  if (sel && is_rd) begin
                     mdio_o  <= data_sh[15];
                     data_sh <= {data_sh[14:0], 1'b0};
                  end
               end
            end
            S_DATA: begin
               // Read frames shift out the MSB; write frames fill the same register from MDIO.
               cnt     <= cnt + 4'd1;
               data_sh <= {data_sh[14:0], mdio_s3};
               if (sel && is_rd) mdio_o <= data_sh[15];
               if (cnt == 4'd15) begin
                  state   <= S_IDLE;
                  pre_cnt <= 6'd0;
                  busy    <= 1'b0;
                  mdio_oe <= 1'b0;
                  mdio_o  <= 1'b0;
                  if (sel && !is_rd) begin
                     wr_en   <= 1'b1;
                     wr_data <= {data_sh[14:0], mdio_s3};
                  end
               end
            end
            default: begin
               state <= S_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_mdio_responder.sv
// +----------------------------------------------------------------------------+
// | tb_mdio_responder : directed MDIO master frames against mdio_responder.   |
// | Revision 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_mdio_responder;

   typedef struct {
      int          pre;
      logic [1:0]  op;
      logic [4:0]  phy;
      logic [4:0]  regad;
      logic [15:0] data;
      logic [15:0] rdd;
      int          exp_wr;
      int          exp_rd;
      int          exp_busy;
   } vec_t;

`ifdef MDIO_RESPONDER_PREAMBLE_SUPPRESS_EN
   localparam int SHORT_OK = 1;
`else
   localparam int SHORT_OK = 0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        mdc;
   logic        m_oe;
   logic        m_val;
   logic        bus;
   logic        mdio_o;
   logic        mdio_oe;
   logic [4:0]  reg_addr;
   logic        rd_req;
   logic [15:0] rd_data;
   logic        wr_en;
   logic [15:0] wr_data;
   logic        busy;

   // Bus has a pull-up when neither side drives it.
   assign bus = mdio_oe ? mdio_o : (m_oe ? m_val : 1'b1);

   mdio_responder #(.PHY_ADDR(5'd1)) dut (
      .clk      (clk),
      .reset    (reset),
      .mdc_i    (mdc),
      .mdio_i   (bus),
      .mdio_o   (mdio_o),
      .mdio_oe  (mdio_oe),
      .reg_addr (reg_addr),
      .rd_req   (rd_req),
      .rd_data  (rd_data),
      .wr_en    (wr_en),
      .wr_data  (wr_data),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   int          wr_cnt = 0;
   int          rd_cnt = 0;
   int          oe_cnt = 0;
   int          busy_cnt = 0;
   logic [4:0]  wr_addr_s = 5'd0;
   logic [15:0] wr_data_s = 16'd0;
   logic [4:0]  rd_addr_s = 5'd0;

   always @(negedge clk) begin
      if (wr_en) begin
         wr_cnt    = wr_cnt + 1;
         wr_addr_s = reg_addr;
         wr_data_s = wr_data;
      end
      if (rd_req) begin
         rd_cnt    = rd_cnt + 1;
         rd_addr_s = reg_addr;
      end
      if (mdio_oe) oe_cnt = oe_cnt + 1;
      if (busy) busy_cnt = busy_cnt + 1;
   end

   int          total = 0;
   int          bad = 0;
   logic [16:0] rd_bits;
   int          oe_periods;
   logic [4:0]  last_addr;
   logic [15:0] last_wdata;
   vec_t        vecs[8];
   vec_t        rv;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total = total + 1;
      if (act !== exp) begin
         bad = bad + 1;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic clks(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // One MDC period: low half, master sample, rise, high half, fall.
   task automatic mdc_bit(input logic v, input logic drv, input int idx);
      m_oe  = drv;
      m_val = v;
      clks(8);
      if (idx >= 16 && idx <= 32) rd_bits = {rd_bits[15:0], bus};
      if (idx >= 1 && mdio_oe) oe_periods = oe_periods + 1;
      mdc = 1'b1;
      clks(8);
      mdc = 1'b0;
   endtask

   task automatic frame(input vec_t v, input int abort_edge);
      logic [31:0] w;
      logic        rd;
      w  = {2'b01, v.op, v.phy, v.regad, 2'b10, v.data};
      rd = (v.op == 2'b10);
      rd_data    = v.rdd;
      rd_bits    = 17'd0;
      oe_periods = 0;
      for (int i = 0; i < v.pre; i++) mdc_bit(1'b1, 1'b1, 0);
      for (int i = 1; i <= 32; i++) begin
         mdc_bit(w[32-i], !(rd && i >= 15), i);
         if (i == abort_edge) begin
            m_oe = 1'b0;
            return;
         end
      end
      m_oe = 1'b0;
      clks(8);
   endtask

   task automatic run_vec(input vec_t v);
      int wr0, rd0, oe0, b0;
      wr0 = wr_cnt;
      rd0 = rd_cnt;
      oe0 = oe_cnt;
      b0  = busy_cnt;
      frame(v, 0);
      check("wr_pulses", wr_cnt - wr0, v.exp_wr);
      check("rd_pulses", rd_cnt - rd0, v.exp_rd);
      check("oe_seen", (oe_cnt != oe0) ? 1 : 0, v.exp_rd);
      check("busy_seen", (busy_cnt != b0) ? 1 : 0, v.exp_busy);
      check("busy_end", busy, 0);
      check("oe_end", mdio_oe, 0);
      if (v.exp_wr != 0) begin
         check("wr_addr", wr_addr_s, v.regad);
         check("wr_data", wr_data_s, v.data);
         last_addr  = v.regad;
         last_wdata = v.data;
      end
      if (v.exp_rd != 0) begin
         check("rd_addr", rd_addr_s, v.regad);
         check("rd_bits", rd_bits, {1'b0, v.rdd});
         check("oe_periods", oe_periods, 17);
         last_addr = v.regad;
      end
      check("reg_addr_hold", reg_addr, last_addr);
      check("wr_data_hold", wr_data, last_wdata);
   endtask

   initial begin
      //          pre op     phy    reg    data      rdd       wr rd busy
      vecs[0] = '{32, 2'b01, 5'd1, 5'h04, 16'hA5C3, 16'h0000, 1, 0, 1};
      vecs[1] = '{32, 2'b10, 5'd1, 5'h02, 16'h0000, 16'h0141, 0, 1, 1};
      vecs[2] = '{32, 2'b01, 5'd3, 5'h07, 16'h1234, 16'h0000, 0, 0, 1};
      vecs[3] = '{32, 2'b01, 5'd1, 5'h1F, 16'h5A0F, 16'h0000, 1, 0, 1};
      vecs[4] = '{20, 2'b01, 5'd1, 5'h06, 16'hBEEF, 16'h0000, SHORT_OK, 0, SHORT_OK};
      vecs[5] = '{32, 2'b11, 5'd1, 5'h04, 16'hFFFF, 16'h0000, 0, 0, 1};
      vecs[6] = '{32, 2'b10, 5'd1, 5'h1E, 16'h0000, 16'h8001, 0, 1, 1};
      vecs[7] = '{32, 2'b00, 5'd1, 5'h04, 16'h3333, 16'h0000, 0, 0, 1};

      reset   = 1'b1;
      mdc     = 1'b0;
      m_oe    = 1'b0;
      m_val   = 1'b1;
      rd_data = 16'd0;
      last_addr  = 5'd0;
      last_wdata = 16'd0;
      clks(4);
      check("rst_oe", mdio_oe, 0);
      check("rst_mdio_o", mdio_o, 0);
      check("rst_rd_req", rd_req, 0);
      check("rst_wr_en", wr_en, 0);
      check("rst_reg_addr", reg_addr, 0);
      check("rst_wr_data", wr_data, 0);
      check("rst_busy", busy, 0);
      reset = 1'b0;
      clks(4);

      for (int i = 0; i < 8; i++) run_vec(vecs[i]);

      // Reset in the middle of read data bit 8, then a clean read.
      rv = '{32, 2'b10, 5'd1, 5'h0A, 16'h0000, 16'h3C5A, 0, 1, 1};
      frame(rv, 24);
      check("pre_rst_oe", mdio_oe, 1);
      check("pre_rst_busy", busy, 1);
      reset = 1'b1;
      clks(1);
      check("mid_rst_oe", mdio_oe, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_reg_addr", reg_addr, 0);
      reset = 1'b0;
      last_addr  = 5'd0;
      last_wdata = 16'd0;
      clks(4);
      rv = '{32, 2'b10, 5'd1, 5'h09, 16'h0000, 16'hC0DE, 0, 1, 1};
      run_vec(rv);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
